// File: rtl/led_pattern_sequencer.sv
// Button-driven LED pattern engine: synchronised/debounced buttons select one of
// four display modes, and a step timer advances the active pattern on o_led.
module led_pattern_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_CYCLES     = 3125000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_btn,
    output logic [7:0] o_led,
    output logic [1:0] o_mode
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    logic [2:0]      btn_meta_reg;
    logic [2:0]      btn_sync_reg;
    logic [2:0]      btn_deb;
    logic [2:0]      btn_deb_prev_reg;
    logic [2:0]      press;

    mode_t           mode_reg;
    mode_t           mode_next;
    logic            mode_change;
    logic            next_evt;
    logic            prev_evt;
    logic            paused_reg;
    logic [ST_W-1:0] step_cnt_reg;
    logic            tick;
    logic [7:0]      led_reg;
    logic            dir_left_reg;
    logic [3:0]      level_reg;
    logic            level_up_reg;
    logic [3:0]      pwm_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta_reg     <= '0;
            btn_sync_reg     <= '0;
            btn_deb_prev_reg <= '0;
        end else begin
            btn_meta_reg     <= i_btn;
            btn_sync_reg     <= btn_meta_reg;
            btn_deb_prev_reg <= btn_deb;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
            logic [DB_W-1:0] cnt_reg;
            logic            deb_reg;

            // Any agreement between synced and debounced value restarts the stability window.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_reg <= '0;
                    deb_reg <= 1'b0;
                end else if (btn_sync_reg[gi] == deb_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_reg <= '0;
                    deb_reg <= btn_sync_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + DB_W'(1);
                end
            end

            assign btn_deb[gi] = deb_reg;
        end
    endgenerate

    assign press    = btn_deb & ~btn_deb_prev_reg;
    assign next_evt = press[1] & ~press[2];
    assign prev_evt = press[2] & ~press[1];
    assign mode_change = next_evt | prev_evt;
    assign tick     = !paused_reg && (step_cnt_reg == ST_W'(STEP_CYCLES - 1));

    always_comb begin
        mode_next = mode_reg;
        if (next_evt) begin
            mode_next = mode_t'(mode_reg + 2'd1);
        end else if (prev_evt) begin
            mode_next = mode_t'(mode_reg - 2'd1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_reg     <= MODE_COUNT;
            paused_reg   <= 1'b0;
            step_cnt_reg <= '0;
            led_reg      <= 8'h00;
            dir_left_reg <= 1'b1;
            level_reg    <= 4'd0;
            level_up_reg <= 1'b1;
            pwm_reg      <= 4'd0;
        end else begin
            pwm_reg <= pwm_reg + 4'd1;
            if (press[0]) begin
                paused_reg <= ~paused_reg;
            end

            if (mode_change) begin
                mode_reg     <= mode_next;
                step_cnt_reg <= '0;
                dir_left_reg <= 1'b1;
                level_reg    <= 4'd0;
                level_up_reg <= 1'b1;
                case (mode_next)
                    MODE_COUNT:   led_reg <= 8'h00;
                    MODE_CHASE:   led_reg <= 8'h01;
                    MODE_BOUNCE:  led_reg <= 8'h01;
                    MODE_BREATHE: led_reg <= 8'h00;
                endcase
            end else begin
                if (!paused_reg) begin
                    step_cnt_reg <= tick ? '0 : step_cnt_reg + ST_W'(1);
                end
                case (mode_reg)
                    MODE_COUNT: begin
                        if (tick) led_reg <= led_reg + 8'd1;
                    end
                    MODE_CHASE: begin
                        if (tick) led_reg <= {led_reg[6:0], led_reg[7]};
                    end
                    MODE_BOUNCE: begin
                        // Direction flips on the edge that produces an end position.
                        if (tick) begin
                            if (dir_left_reg) begin
                                led_reg <= led_reg << 1;
                                if (led_reg == 8'h40) dir_left_reg <= 1'b0;
                            end else begin
                                led_reg <= led_reg >> 1;
                                if (led_reg == 8'h02) dir_left_reg <= 1'b1;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        // PWM output refreshes every cycle, even while paused.
                        led_reg <= {8{pwm_reg < level_reg}};
                        if (tick) begin
                            if (level_up_reg) begin
                                level_reg <= level_reg + 4'd1;
                                if (level_reg == 4'd14) level_up_reg <= 1'b0;
                            end else begin
                                level_reg <= level_reg - 4'd1;
                                if (level_reg == 4'd1) level_up_reg <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_led  = led_reg;
    assign o_mode = mode_reg;

endmodule
